// File: rtl/assoc_wb_cache_if.sv
// Processor word port and block-wide memory port of assoc_wb_cache.
// slave is the cache side, master is the processor/memory environment.
interface assoc_wb_cache_if #(
    parameter int ADDR_W = 30,
    parameter int WORDS  = 4
) ();
    localparam int OFF_W = $clog2(WORDS);

    logic                      proc_read;
    logic                      proc_write;
    logic [ADDR_W-1:0]         proc_addr;
    logic [31:0]               proc_wdata;
    logic [31:0]               proc_rdata;
    logic                      proc_stall;
    logic                      mem_read;
    logic                      mem_write;
    logic [ADDR_W-OFF_W-1:0]   mem_addr;
    logic [32*WORDS-1:0]       mem_wdata;
    logic [32*WORDS-1:0]       mem_rdata;
    logic                      mem_ready;

    modport slave (
        input  proc_read, proc_write, proc_addr, proc_wdata,
        input  mem_rdata, mem_ready,
        output proc_rdata, proc_stall,
        output mem_read, mem_write, mem_addr, mem_wdata
    );

    modport master (
        output proc_read, proc_write, proc_addr, proc_wdata,
        output mem_rdata, mem_ready,
        input  proc_rdata, proc_stall,
        input  mem_read, mem_write, mem_addr, mem_wdata
    );
endinterface

// File: rtl/assoc_wb_cache.sv
// N-way set-associative write-back, write-allocate cache with true-LRU
// replacement and saturating hit/miss counters.
module assoc_wb_cache #(
    parameter int ADDR_W = 30,
    parameter int WORDS  = 4,
    parameter int SETS   = 4,
    parameter int WAYS   = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             proc_reset_n,
    assoc_wb_cache_if.slave  bus,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int IW    = (IDX_W > 0) ? IDX_W : 1;
    localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BLK_W = 32 * WORDS;

    typedef enum logic [1:0] {
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_valid [WAYS][SETS];
    logic             r_dirty [WAYS][SETS];
    logic [TAG_W-1:0] r_tag   [WAYS][SETS];
    logic [BLK_W-1:0] r_data  [WAYS][SETS];
    logic [WW-1:0]    r_age   [SETS][WAYS];
    logic [WW-1:0]    r_victim;
    logic             r_replay;
    logic [CNT_W-1:0] r_hits;
    logic [CNT_W-1:0] r_misses;

    logic [TAG_W-1:0]        w_tag;
    logic [OFF_W-1:0]        w_off;
    logic [IW-1:0]           w_idx;
    logic [ADDR_W-OFF_W-1:0] w_wb_addr;
    logic                    w_req;
    logic                    w_hit;
    logic [WW-1:0]           w_hit_way;
    logic                    w_free;
    logic [WW-1:0]           w_victim;
    logic                    w_hit_fire;
    logic                    w_miss_fire;
    logic                    w_fill;
    logic [31:0]             w_word;

    assign w_tag = bus.proc_addr[ADDR_W-1 -: TAG_W];
    assign w_off = bus.proc_addr[OFF_W-1:0];

    generate
        if (IDX_W > 0) begin : g_idx
            assign w_idx     = bus.proc_addr[OFF_W +: IW];
            assign w_wb_addr = {r_tag[r_victim][w_idx], w_idx};
        end else begin : g_noidx
            assign w_idx     = '0;
            assign w_wb_addr = r_tag[r_victim][w_idx];
        end
    endgenerate

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w][w_idx] && r_tag[w][w_idx] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = WW'(w);
            end
        end
    end

    // Invalid ways are filled lowest-first; only a full set consults LRU.
    always_comb begin
        w_free   = 1'b0;
        w_victim = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_free && !r_valid[w][w_idx]) begin
                w_free   = 1'b1;
                w_victim = WW'(w);
            end
        end
        if (!w_free) begin
            for (int w = 0; w < WAYS; w++) begin
                if (r_age[w_idx][w] == WW'(WAYS - 1)) begin
                    w_victim = WW'(w);
                end
            end
        end
    end

    assign w_req       = bus.proc_read | bus.proc_write;
    assign w_hit_fire  = (r_state == S_COMPARE) && w_req && w_hit;
    assign w_miss_fire = (r_state == S_COMPARE) && w_req && !w_hit;
    assign w_fill      = (r_state == S_ALLOCATE) && bus.mem_ready;
    assign w_word      = r_data[w_hit_way][w_idx][{w_off, 5'd0} +: 32];

    assign bus.proc_stall = w_req && !w_hit_fire;
    assign bus.proc_rdata = w_hit_fire ? w_word : 32'd0;
    assign bus.mem_write  = (r_state == S_WRITEBACK);
    assign bus.mem_read   = (r_state == S_ALLOCATE);
    assign bus.mem_addr   = bus.mem_write ? w_wb_addr
                                          : bus.proc_addr[ADDR_W-1:OFF_W];
    assign bus.mem_wdata  = r_data[r_victim][w_idx];
    assign hit_count      = r_hits;
    assign miss_count     = r_misses;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_COMPARE: begin
                if (w_miss_fire) begin
                    w_next = (r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx])
                             ? S_WRITEBACK : S_ALLOCATE;
                end
            end
            S_WRITEBACK: if (bus.mem_ready) w_next = S_ALLOCATE;
            S_ALLOCATE:  if (bus.mem_ready) w_next = S_COMPARE;
            default:     w_next = S_COMPARE;
        endcase
    end

    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            r_state  <= S_COMPARE;
            r_victim <= '0;
            r_replay <= 1'b0;
            r_hits   <= '0;
            r_misses <= '0;
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    r_valid[w][s] <= 1'b0;
                    r_dirty[w][s] <= 1'b0;
                    r_age[s][w]   <= WW'(w);
                end
            end
        end else begin
            r_state <= w_next;
            if (w_hit_fire) begin
                r_replay <= 1'b0;
                if (!r_replay && r_hits != '1) r_hits <= r_hits + 1'b1;
                if (bus.proc_write) r_dirty[w_hit_way][w_idx] <= 1'b1;
                for (int w = 0; w < WAYS; w++) begin
                    if (WW'(w) == w_hit_way) begin
                        r_age[w_idx][w] <= '0;
                    end else if (r_age[w_idx][w] < r_age[w_idx][w_hit_way]) begin
                        r_age[w_idx][w] <= r_age[w_idx][w] + 1'b1;
                    end
                end
            end
            if (w_miss_fire) begin
                r_victim <= w_victim;
                if (r_misses != '1) r_misses <= r_misses + 1'b1;
            end
            if (r_state == S_WRITEBACK && bus.mem_ready) begin
                r_dirty[r_victim][w_idx] <= 1'b0;
            end
            if (w_fill) begin
                r_valid[r_victim][w_idx] <= 1'b1;
                r_dirty[r_victim][w_idx] <= 1'b0;
                r_replay                 <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        if (w_hit_fire && bus.proc_write) begin
            r_data[w_hit_way][w_idx][{w_off, 5'd0} +: 32] <= bus.proc_wdata;
        end
        if (w_fill) begin
            r_data[r_victim][w_idx] <= bus.mem_rdata;
            r_tag[r_victim][w_idx]  <= w_tag;
        end
    end
endmodule

// File: doc/assoc_wb_cache.md
# assoc_wb_cache

Parametrised N-way set-associative write-back, write-allocate cache. It sits between the processor word interface (word address, 32-bit data, stall) and a block-wide memory or next-level port (block address, WORDS×32 data, one-cycle ready pulse). It generalises the fixed-geometry cache stages with configurable sets, ways and block size, true-LRU replacement, and saturating hit/miss counters.

## Interface
- ADDR_W, 30, processor word-address width
- WORDS, 4, 32-bit words per block; power of 2, ≥2; OFF_W = log2(WORDS)
- SETS, 4, number of sets; power of 2, ≥1; IDX_W = log2(SETS), 0 allowed
- WAYS, 2, associativity; one of 1, 2, 4
- CNT_W, 16, width of statistics counters
- TAG_W = ADDR_W − IDX_W − OFF_W (derived)

Ports:
- clk  in  1  clock; all state updates on rising edge
- proc_reset_n  in  1  reset; asynchronous, active-low
- proc_read  in  1  read request; held until proc_stall low
- proc_write  in  1  write request; held until proc_stall low
- proc_addr  in  ADDR_W  word address {tag, index, offset}
- proc_wdata  in  32  write data
- proc_rdata  out  32  read data; valid when a request is active and proc_stall is low
- proc_stall  out  1  request not complete this cycle
- mem_read  out  1  block fetch request
- mem_write  out  1  block write-back request
- mem_addr  out  ADDR_W−OFF_W  block address
- mem_wdata  out  32·WORDS  write-back block; word k at bits [32k+31:32k]
- mem_rdata  in  32·WORDS  fetched block, same packing
- mem_ready  in  1  one-cycle pulse; sampled only at a clock edge while mem_read or mem_write is high
- hit_count  out  CNT_W  saturating count of first-lookup hits
- miss_count  out  CNT_W  saturating count of misses

## Operation
- Per way and set: valid, dirty, tag, WORDS×32 data. Per set: LRU ages, log2(WAYS) bits per way.
- States: COMPARE, WRITEBACK, ALLOCATE.
- COMPARE, no request: proc_stall=0, proc_rdata=0.
- COMPARE, hit (valid && tag match): proc_stall=0. Read: proc_rdata = addressed word, combinational. Write: word updated and dirty set at the edge. LRU is touched.
- COMPARE, miss: proc_stall=1, miss_count+1. Victim is the lowest-index invalid way, else the way with age WAYS−1. Go to WRITEBACK if the victim is valid && dirty, else ALLOCATE. Latch the victim way.
- WRITEBACK: mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim block. On mem_ready: clear dirty, go to ALLOCATE.
- ALLOCATE: mem_read=1, mem_addr=proc_addr[ADDR_W−1:OFF_W]. On mem_ready: write block, tag, valid=1, dirty=0, set the replay flag, go to COMPARE.
- The replayed lookup hits and completes normally. It does not increment hit_count. The replay flag clears when the request completes.
- LRU touch: accessed way age←0; ways with age less than the old age increment. Reset ages: way i = i. Ages always form a permutation. WAYS=1: no LRU state, victim is way 0.
- proc_read && proc_write both high: treated as a write. proc_rdata still shows the pre-write word.
- proc_stall = request && !(state==COMPARE && hit).
- mem_read and mem_write are decoded from state only, never both high.
- Counters saturate at all-ones; they do not wrap.

## Timing
- Reset (async, any state): state→COMPARE, all valid/dirty=0, ages=way index, replay=0, counters=0. mem_read=mem_write=0 immediately. Data and tag arrays are not reset. With no request active, proc_stall=0 and proc_rdata=0.
- Hit: 0 stall cycles.
- Clean miss: 1 COMPARE cycle, then ALLOCATE until mem_ready, then 1 replay cycle. Stall = 1 + L cycles, where L is the number of cycles ALLOCATE waits, inclusive of the mem_ready cycle.
- Dirty miss: adds the WRITEBACK wait before ALLOCATE.
- mem_read or mem_write drops in the cycle after mem_ready is sampled.
- mem_ready while neither request is high: ignored.
- Requests change only after a non-stalled cycle. Changing the address while stalled is illegal and unchecked.

## Test plan
Defaults: TAG_W=26, 2 index bits, 2 offset bits.
- Reset, then read addr 0x0 with mem_rdata={4,3,2,1} and mem_ready 3 cycles after mem_read rises -> mem_addr=0x0; proc_rdata=1 on replay; miss_count=1, hit_count=0; stall for 4 cycles.
- Read 0x1, then write 0x0 with 0xDEAD -> both no stall, hit_count=2; a following read of 0x0 returns 0xDEAD.
- Read 0x10 (fill way1, data {8,7,6,5}), then read 0x20 -> WRITEBACK first with mem_addr=0x0, mem_wdata={4,3,2,0xDEAD}; then ALLOCATE with mem_addr=0x8; way1 (tag 1) retained, and re-reading 0x10 hits.
- Simultaneous proc_read && proc_write hit on 0x1 with 0x55 -> no stall, proc_rdata=2 that cycle, stored word becomes 0x55, dirty set.
- Drop proc_reset_n mid-ALLOCATE -> mem_read falls immediately; after release, read 0x0 misses again and counters restart at 0.
- CNT_W=2, WAYS=4, SETS=1: six misses to distinct tags -> miss_count stays 3; victims are the invalid ways 0–3, then LRU way 0, then way 1.
